cpc_bus_cycle_ctl: RTL and testbench

Front-end Z80 bus cycle tracker for the CPC RAM expansion CPLD. It sits directly upstream of the RAM banking/decoder stage. It samples the raw Z80 control strobes on the CPU clock and classifies each bus cycle. It emits registered memory-cycle qualifiers and single-cycle pulses for 0x7Fxx RAM/ROM configuration writes, and latches the DIP settings during reset so that the DIP pins can be reused as address outputs.

---
 rtl/cpc_bus_cycle_ctl_pkg.sv | 19 +
 rtl/cpc_bus_cycle_ctl_if.sv | 15 +
 rtl/cpc_bus_cycle_ctl_timer.sv | 26 ++
 rtl/cpc_bus_cycle_ctl.sv | 116 +++++++++++
 tb/tb_cpc_bus_cycle_ctl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cpc_bus_cycle_ctl_pkg.sv
// Shared types and constants for the CPC Z80 bus cycle tracker.
package cpc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEM     = 3'd1,
        ST_RFSH    = 3'd2,
        ST_IO      = 3'd3,
        ST_IO_DONE = 3'd4,
        ST_ERR     = 3'd5
    } bus_state_e;

    // data[7:6] codes of a 0x7Fxx gate-array style config write
    localparam logic [1:0] CFG_RAM = 2'b11;
    localparam logic [1:0] CFG_ROM = 2'b10;

    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/cpc_bus_cycle_ctl_if.sv
// Raw Z80 bus strobes, address and data as seen by the CPLD.
interface cpc_bus_cycle_ctl_if;
    logic       mreq_b;
    logic       iorq_b;
    logic       rd_b;
    logic       wr_b;
    logic       rfsh_b;
    logic       m1_b;
    logic       adr15;
    logic       adr8;
    logic [7:0] data;

    modport master (output mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, adr15, adr8, data);
    modport slave  (input  mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, adr15, adr8, data);
endinterface

// File: rtl/cpc_bus_cycle_ctl_timer.sv
// Saturating cycle-length counter; term fires on the clock the count reaches TIMEOUT.
module cpc_cycle_timer #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

    assign term = en && !clr && (cnt == TERM_M1);

endmodule

// File: rtl/cpc_bus_cycle_ctl.sv
// Z80 bus cycle classifier: memory-cycle qualifiers, 0x7Fxx config strobes,
// bus timeout detection and DIP capture during reset.
module cpc_bus_cycle_ctl
    import cpc_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    cpc_bus_cycle_ctl_if.slave         bus,
    input  logic [3:0]                 dip,
    output logic [3:0]                 dip_q,
    output logic                       mem_cyc,
    output logic                       mwr_cyc,
    output logic                       mwr_win,
    output logic                       ram_cfg_stb,
    output logic                       rom_cfg_stb,
    output logic [7:0]                 cfg_data,
    output logic                       cfg_adr8,
    output logic                       bus_err
);

    bus_state_e state, state_nxt;
    logic       busy, tmo, io_hit, stb;
    logic       mem_cyc_nxt, mwr_cyc_nxt, mwr_win_nxt;
    logic       ram_stb_nxt, rom_stb_nxt, bus_err_nxt, cfg_adr8_nxt;
    logic [7:0] cfg_data_nxt;

    assign busy = (state == ST_MEM) || (state == ST_RFSH) ||
                  (state == ST_IO)  || (state == ST_IO_DONE);

    // Count is held clear for the whole idle period, so it restarts on every IDLE exit
    cpc_cycle_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_IDLE),
        .en    (busy),
        .term  (tmo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_cyc     <= 1'b0;
            mwr_cyc     <= 1'b0;
            mwr_win     <= 1'b0;
            ram_cfg_stb <= 1'b0;
            rom_cfg_stb <= 1'b0;
            cfg_data    <= '0;
            cfg_adr8    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_cyc     <= mem_cyc_nxt;
            mwr_cyc     <= mwr_cyc_nxt;
            mwr_win     <= mwr_win_nxt;
            ram_cfg_stb <= ram_stb_nxt;
            rom_cfg_stb <= rom_stb_nxt;
            cfg_data    <= cfg_data_nxt;
            cfg_adr8    <= cfg_adr8_nxt;
            bus_err     <= bus_err_nxt;
        end
    end

    // DIP pins become address outputs once reset drops, so only sample them in reset
    always_ff @(posedge clk) begin
        if (reset)
            dip_q <= dip;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!bus.mreq_b)
                    state_nxt = bus.rfsh_b ? ST_MEM : ST_RFSH;
                else if (!bus.iorq_b)
                    state_nxt = bus.m1_b ? ST_IO : ST_IO_DONE;
            end
            ST_MEM, ST_RFSH: begin
                if (tmo)              state_nxt = ST_ERR;
                else if (bus.mreq_b)  state_nxt = ST_IDLE;
            end
            ST_IO: begin
                if (tmo)              state_nxt = ST_ERR;
                else if (bus.iorq_b)  state_nxt = ST_IDLE;
                else if (!bus.wr_b)   state_nxt = ST_IO_DONE;
            end
            ST_IO_DONE: begin
                if (tmo)              state_nxt = ST_ERR;
                else if (bus.iorq_b)  state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (bus.mreq_b && bus.iorq_b) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign io_hit = !bus.wr_b && !bus.adr15 && bus.data[7];
    // Decode only on the single IO -> IO_DONE transition, so one strobe per cycle at most
    assign stb    = (state == ST_IO) && (state_nxt == ST_IO_DONE) && io_hit;

    always_comb begin
        mem_cyc_nxt  = (state_nxt == ST_MEM);
        mwr_cyc_nxt  = (state_nxt == ST_MEM) && (mwr_cyc || (!bus.mreq_b && bus.rd_b));
        mwr_win_nxt  = (state == ST_MEM) && (state_nxt == ST_MEM) && (mwr_win || !bus.wr_b);
        ram_stb_nxt  = stb && (bus.data[7:6] == CFG_RAM);
        rom_stb_nxt  = stb && (bus.data[7:6] == CFG_ROM);
        cfg_data_nxt = stb ? bus.data : cfg_data;
        cfg_adr8_nxt = stb ? bus.adr8 : cfg_adr8;
        bus_err_nxt  = bus_err || (state_nxt == ST_ERR);
    end

endmodule

// File: tb/tb_cpc_bus_cycle_ctl.sv
// Scoreboard bench: each driven clock pushes the outputs expected after the next edge.
module tb_cpc_bus_cycle_ctl;

    // {mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b}
    localparam logic [5:0] IDL  = 6'b111111;
    localparam logic [5:0] MRD  = 6'b010111;
    localparam logic [5:0] MWA  = 6'b011111;
    localparam logic [5:0] MWR  = 6'b011011;
    localparam logic [5:0] IOA  = 6'b101111;
    localparam logic [5:0] IOW  = 6'b101011;
    localparam logic [5:0] INTA = 6'b101110;
    localparam logic [5:0] RFS  = 6'b011101;

    typedef struct {
        string      tag;
        logic [4:0] flg;   // {mem_cyc, mwr_cyc, mwr_win, ram_cfg_stb, rom_cfg_stb}
        logic [7:0] cd;
        logic       a8;
        logic       err;
        logic [3:0] dq;
    } exp_t;

    logic       clk, reset;
    logic [3:0] dip, dip_q;
    logic       mem_cyc, mwr_cyc, mwr_win, ram_cfg_stb, rom_cfg_stb, cfg_adr8, bus_err;
    logic [7:0] cfg_data;

    cpc_bus_cycle_ctl_if bus();

    cpc_bus_cycle_ctl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dip         (dip),
        .dip_q       (dip_q),
        .mem_cyc     (mem_cyc),
        .mwr_cyc     (mwr_cyc),
        .mwr_win     (mwr_win),
        .ram_cfg_stb (ram_cfg_stb),
        .rom_cfg_stb (rom_cfg_stb),
        .cfg_data    (cfg_data),
        .cfg_adr8    (cfg_adr8),
        .bus_err     (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t       sb[$];
    exp_t       x;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] cur_cd  = 8'h00;
    logic       cur_a8  = 1'b0;
    logic       cur_err = 1'b0;
    logic [3:0] cur_dq  = 4'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic [3:0] dv,
                       input logic [5:0] ctl, input logic a15, input logic a8,
                       input logic [7:0] d, input logic [4:0] e, input bit check);
        exp_t t;
        @(negedge clk);
        reset = rst;
        dip   = dv;
        {bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.rfsh_b, bus.m1_b} = ctl;
        bus.adr15 = a15;
        bus.adr8  = a8;
        bus.data  = d;
        if (check) begin
            t = '{tag, e, cur_cd, cur_a8, cur_err, cur_dq};
            sb.push_back(t);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, ".mem_cyc"}, 32'(mem_cyc),     32'(x.flg[4]));
            chk({x.tag, ".mwr_cyc"}, 32'(mwr_cyc),     32'(x.flg[3]));
            chk({x.tag, ".mwr_win"}, 32'(mwr_win),     32'(x.flg[2]));
            chk({x.tag, ".ram_stb"}, 32'(ram_cfg_stb), 32'(x.flg[1]));
            chk({x.tag, ".rom_stb"}, 32'(rom_cfg_stb), 32'(x.flg[0]));
            chk({x.tag, ".cfg_data"}, 32'(cfg_data),   32'(x.cd));
            chk({x.tag, ".cfg_adr8"}, 32'(cfg_adr8),   32'(x.a8));
            chk({x.tag, ".bus_err"}, 32'(bus_err),     32'(x.err));
            chk({x.tag, ".dip_q"},   32'(dip_q),       32'(x.dq));
        end
    end

    initial begin
        reset = 1'b1;
        dip   = 4'b1011;
        {bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.rfsh_b, bus.m1_b} = IDL;
        bus.adr15 = 1'b1;
        bus.adr8  = 1'b0;
        bus.data  = 8'h00;

        cur_dq = 4'b1011;
        for (int i = 0; i < 3; i++) cyc("rst", 1, 4'b1011, IDL, 1, 0, 8'h00, 5'b00000, 1);
        for (int i = 0; i < 2; i++) cyc("post_rst", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // memory write: mreq T1, wr T2, mreq high T4
        cyc("mw1", 0, 4'b0000, MWA, 1, 0, 8'h00, 5'b11000, 1);
        cyc("mw2", 0, 4'b0000, MWR, 1, 0, 8'h00, 5'b11100, 1);
        cyc("mw3", 0, 4'b0000, MWR, 1, 0, 8'h00, 5'b11100, 1);
        cyc("mw4", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);
        // back-to-back read right after the return to IDLE
        cyc("b2b_rd1", 0, 4'b0000, MRD, 1, 0, 8'h00, 5'b10000, 1);
        cyc("b2b_rd2", 0, 4'b0000, MRD, 1, 0, 8'h00, 5'b10000, 1);
        cyc("b2b_end", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // RAM config write 0xC6, adr8=1
        cyc("ram_a", 0, 4'b0000, IOA, 0, 1, 8'hC6, 5'b00000, 1);
        cur_cd = 8'hC6; cur_a8 = 1'b1;
        cyc("ram_s", 0, 4'b0000, IOW, 0, 1, 8'hC6, 5'b00010, 1);
        cyc("ram_h1", 0, 4'b0000, IOW, 0, 1, 8'hC6, 5'b00000, 1);
        cyc("ram_h2", 0, 4'b0000, IOW, 0, 1, 8'hC6, 5'b00000, 1);
        cyc("ram_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // ROM config write 0x8C, adr8=0, with a WR toggle after the strobe
        cyc("rom_a", 0, 4'b0000, IOA, 0, 0, 8'h8C, 5'b00000, 1);
        cur_cd = 8'h8C; cur_a8 = 1'b0;
        cyc("rom_s", 0, 4'b0000, IOW, 0, 0, 8'h8C, 5'b00001, 1);
        cyc("rom_wh", 0, 4'b0000, IOA, 0, 0, 8'h8C, 5'b00000, 1);
        cyc("rom_wl", 0, 4'b0000, IOW, 0, 0, 8'hC6, 5'b00000, 1);
        cyc("rom_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // data[7]=0, then adr15=1: neither decodes
        cyc("n46_a", 0, 4'b0000, IOA, 0, 1, 8'h46, 5'b00000, 1);
        cyc("n46_w", 0, 4'b0000, IOW, 0, 1, 8'h46, 5'b00000, 1);
        cyc("n46_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);
        cyc("a15_a", 0, 4'b0000, IOA, 1, 1, 8'hC6, 5'b00000, 1);
        cyc("a15_w", 0, 4'b0000, IOW, 1, 1, 8'hC6, 5'b00000, 1);
        cyc("a15_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // interrupt acknowledge
        for (int i = 0; i < 3; i++) cyc("inta", 0, 4'b0000, INTA, 0, 1, 8'hC6, 5'b00000, 1);
        cyc("inta_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // refresh then an immediate read
        cyc("rfsh1", 0, 4'b0000, RFS, 1, 0, 8'h00, 5'b00000, 1);
        cyc("rfsh2", 0, 4'b0000, RFS, 1, 0, 8'h00, 5'b00000, 1);
        cyc("rfsh_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);
        cyc("rd1", 0, 4'b0000, MRD, 1, 0, 8'h00, 5'b10000, 1);
        cyc("rd2", 0, 4'b0000, MRD, 1, 0, 8'h00, 5'b10000, 1);
        cyc("rd_e", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // MREQ stuck low for 20 clocks: bus error after the 15th clock in MEM
        for (int i = 1; i <= 20; i++) begin
            if (i >= 16) cur_err = 1'b1;
            cyc("tmo", 0, 4'b0000, MWA, 1, 0, 8'h00, (i <= 15) ? 5'b11000 : 5'b00000, i != 16);
        end
        cyc("tmo_rel", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);
        cyc("tmo_rd1", 0, 4'b0000, MRD, 1, 0, 8'h00, 5'b10000, 1);
        cyc("tmo_rd2", 0, 4'b0000, IDL, 1, 0, 8'h00, 5'b00000, 1);

        // reset mid IO write: strobe suppressed, config and error cleared, DIP recaptured
        cyc("mrst_a", 0, 4'b0000, IOA, 0, 1, 8'hC6, 5'b00000, 1);
        cur_err = 1'b0; cur_cd = 8'h00; cur_a8 = 1'b0; cur_dq = 4'b0101;
        cyc("mrst_r", 1, 4'b0101, IOW, 0, 1, 8'hC6, 5'b00000, 1);
        cyc("mrst_i", 0, 4'b1111, IDL, 1, 0, 8'h00, 5'b00000, 1);
        cyc("mrst_w", 0, 4'b1111, MWA, 1, 0, 8'h00, 5'b11000, 1);
        cyc("mrst_e", 0, 4'b1111, IDL, 1, 0, 8'h00, 5'b00000, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
